// File: rtl/fetch_stage_if.sv
// +------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory request/response bus          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                Imem_req;
  logic [PC_WIDTH-1:0] Imem_addr;
  logic                Imem_ready;
  logic                Imem_rvalid;
  logic [31:0]         Imem_rdata;

  modport master (
    output Imem_req,
    output Imem_addr,
    input  Imem_ready,
    input  Imem_rvalid,
    input  Imem_rdata
  );

  modport slave (
    input  Imem_req,
    input  Imem_addr,
    output Imem_ready,
    output Imem_rvalid,
    output Imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// +------------------------------------------------------------------+
// | fetch_stage : RV32I IF stage, PC + single-outstanding fetch + IF  |
// | pipeline register with one-word stall buffer.  Rev 1.0            |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_stage #(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  fetch_stage_if.master            imem,
  input  wire logic                Stall,
  input  wire logic                IF_ID_Flush,
  input  wire logic                EX_PC_Branch,
  input  wire logic [PC_WIDTH-1:0] EX_Branch_target,
  input  wire logic                ID_Jump,
  input  wire logic [PC_WIDTH-1:0] ID_Jump_target,
  output logic      [31:0]         IF_Instruction,
  output logic      [PC_WIDTH-1:0] IF_PC,
  output logic                     IF_Valid
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [31:0]         hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                hold_valid_q, hold_valid_d;
  logic [31:0]         if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                if_valid_q, if_valid_d;

  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_req;
  logic                w_handshake;
  logic                w_deliver;

  // Request depends only on registered state so the memory never sees a comb loop.
  assign w_req          = (state_q == S_FETCH) && !hold_valid_q;
  assign w_handshake    = w_req && imem.Imem_ready;
  assign w_redirect     = EX_PC_Branch || ID_Jump;
  assign w_target       = EX_PC_Branch ? EX_Branch_target : ID_Jump_target;
  assign w_deliver      = (state_q == S_WAIT) && imem.Imem_rvalid && !w_redirect && !IF_ID_Flush;

  assign imem.Imem_req  = w_req;
  assign imem.Imem_addr = pc_q;
  assign IF_Instruction = if_instr_q;
  assign IF_PC          = if_pc_q;
  assign IF_Valid       = if_valid_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (w_handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = w_redirect ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.Imem_rvalid) state_d = S_FETCH;
        else if (w_redirect)  state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem.Imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    if (w_redirect) pc_d = w_target;
  end

  always_comb begin
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_valid_d = hold_valid_q;
    if (IF_ID_Flush) begin
      if_instr_d   = NOP_INSTR;
      if_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
    end else if (Stall) begin
      if (w_deliver) begin
        hold_instr_d = imem.Imem_rdata;
        hold_pc_d    = req_pc_q;
        hold_valid_d = 1'b1;
      end
    end else if (hold_valid_q) begin
      if_instr_d   = hold_instr_q;
      if_pc_d      = hold_pc_q;
      if_valid_d   = 1'b1;
      hold_valid_d = w_deliver;
      if (w_deliver) begin
        hold_instr_d = imem.Imem_rdata;
        hold_pc_d    = req_pc_q;
      end
    end else if (w_deliver) begin
      if_instr_d = imem.Imem_rdata;
      if_pc_d    = req_pc_q;
      if_valid_d = 1'b1;
    end else begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
      hold_valid_q <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= RESET_PC;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_valid_q <= hold_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_valid_q   <= if_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +------------------------------------------------------------------+
// | tb_fetch_stage : directed + randomized bench for fetch_stage      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall = 1'b0, IF_ID_Flush = 1'b0, EX_PC_Branch = 1'b0, ID_Jump = 1'b0;
  logic [31:0] EX_Branch_target = '0, ID_Jump_target = '0;
  logic [31:0] IF_Instruction, IF_PC;
  logic        IF_Valid;

  int total = 0;
  int bad   = 0;

  // Memory model: one queue entry per accepted request, counting down to its response.
  int          q_cnt[$];
  logic [31:0] q_addr[$];
  int          lat_min = 1, lat_max = 1;
  int          ready_mode = 0;   // 0 always ready, 1 random, 2 never
  logic [31:0] prog [16];

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_WIDTH(32)) bus ();

  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (bus),
    .Stall            (Stall),
    .IF_ID_Flush      (IF_ID_Flush),
    .EX_PC_Branch     (EX_PC_Branch),
    .EX_Branch_target (EX_Branch_target),
    .ID_Jump          (ID_Jump),
    .ID_Jump_target   (ID_Jump_target),
    .IF_Instruction   (IF_Instruction),
    .IF_PC            (IF_PC),
    .IF_Valid         (IF_Valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd64) return prog[a[5:2]];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic pick_ready();
    if (ready_mode == 0) return 1'b1;
    if (ready_mode == 2) return 1'b0;
    return ($urandom_range(0, 9) < 7);
  endfunction

  // One clock: sample the bus before the edge, update the memory model, drive the next cycle.
  task automatic tick();
    logic        hs, rv;
    logic [31:0] a;
    hs = bus.Imem_req && bus.Imem_ready;
    a  = bus.Imem_addr;
    rv = bus.Imem_rvalid;
    @(posedge clk);
    #1;
    if (rv && q_cnt.size() > 0) begin
      void'(q_cnt.pop_front());
      void'(q_addr.pop_front());
    end
    if (hs) begin
      total++;
      if (q_cnt.size() != 0) begin
        bad++;
        $display("FAIL single_outstanding: pending=%0d required=0", q_cnt.size());
      end
      q_cnt.push_back($urandom_range(lat_max, lat_min));
      q_addr.push_back(a);
    end
    if (q_cnt.size() > 0 && q_cnt[0] > 0) q_cnt[0] = q_cnt[0] - 1;
    bus.Imem_rvalid = (q_cnt.size() > 0 && q_cnt[0] == 0);
    bus.Imem_rdata  = bus.Imem_rvalid ? mem_word(q_addr[0]) : 32'hDEAD_BEEF;
    bus.Imem_ready  = pick_ready();
  endtask

  task automatic apply_reset();
    Stall = 0; IF_ID_Flush = 0; EX_PC_Branch = 0; ID_Jump = 0;
    rst_n = 1'b0;
    q_cnt.delete();
    q_addr.delete();
    bus.Imem_rvalid = 1'b0;
    bus.Imem_rdata  = 32'hDEAD_BEEF;
    bus.Imem_ready  = pick_ready();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1; ready_mode = 0;
    rst_n = 1'b0;
    q_cnt.delete(); q_addr.delete();
    bus.Imem_rvalid = 1'b0; bus.Imem_ready = 1'b1; bus.Imem_rdata = '0;
    @(posedge clk); #1;
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b want=0", IF_Valid); end
    total++; if (IF_Instruction !== NOP) begin bad++; $display("FAIL rst_instr: got=%h want=%h", IF_Instruction, NOP); end
    total++; if (IF_PC !== 32'h0) begin bad++; $display("FAIL rst_pc: got=%h want=0", IF_PC); end
    total++; if (bus.Imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got=%b want=0", bus.Imem_req); end
    rst_n = 1'b1;
    #2;
    total++; if (bus.Imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_cycle1: got=%b want=0", bus.Imem_req); end
    tick();
    total++; if (bus.Imem_req !== 1'b1) begin bad++; $display("FAIL rst_req_cycle2: got=%b want=1", bus.Imem_req); end
    total++; if (bus.Imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got=%h want=0", bus.Imem_addr); end
  endtask

  task automatic test_basic();
    lat_min = 1; lat_max = 1; ready_mode = 0;
    apply_reset();
    tick();  // FETCH
    tick();  // handshake at 0x0
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL basic_pre: got=%b want=0", IF_Valid); end
    tick();  // response lands
    total++; if (IF_Valid !== 1'b1 || IF_Instruction !== 32'h0050_0093 || IF_PC !== 32'h0) begin
      bad++; $display("FAIL basic_first: got=%b/%h/%h want=1/00500093/00000000", IF_Valid, IF_Instruction, IF_PC); end
    total++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h4) begin
      bad++; $display("FAIL basic_addr2: got=%b/%h want=1/00000004", bus.Imem_req, bus.Imem_addr); end
    tick();
    total++; if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
      bad++; $display("FAIL basic_bubble: got=%b/%h want=0/%h", IF_Valid, IF_Instruction, NOP); end
    tick();
    total++; if (IF_Valid !== 1'b1 || IF_Instruction !== 32'h00A0_0113 || IF_PC !== 32'h4) begin
      bad++; $display("FAIL basic_second: got=%b/%h/%h want=1/00a00113/00000004", IF_Valid, IF_Instruction, IF_PC); end
  endtask

  task automatic test_stall();
    lat_min = 3; lat_max = 3; ready_mode = 0;
    apply_reset();
    tick(); tick(); tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (IF_Valid !== 1'b0 || bus.Imem_req !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: valid=%b req=%b want=0/0", i, IF_Valid, bus.Imem_req); end
    end
    Stall = 1'b0;
    tick();
    total++; if (IF_Valid !== 1'b1 || IF_PC !== 32'h0 || IF_Instruction !== prog[0]) begin
      bad++; $display("FAIL stall_release: got=%b/%h/%h want=1/0/%h", IF_Valid, IF_PC, IF_Instruction, prog[0]); end
    total++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h4) begin
      bad++; $display("FAIL stall_resume: got=%b/%h want=1/00000004", bus.Imem_req, bus.Imem_addr); end
  endtask

  task automatic test_branch();
    bit found;
    lat_min = 3; lat_max = 3; ready_mode = 0;
    apply_reset();
    tick(); tick();  // request to 0x0 outstanding
    EX_PC_Branch = 1'b1; EX_Branch_target = 32'h100;
    tick();
    EX_PC_Branch = 1'b0;
    total++; if (bus.Imem_req !== 1'b0) begin bad++; $display("FAIL br_discard_req: got=%b want=0", bus.Imem_req); end
    tick(); tick();  // stale response dropped here
    total++; if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
      bad++; $display("FAIL br_stale: got=%b/%h want=0/%h", IF_Valid, IF_Instruction, NOP); end
    total++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h100) begin
      bad++; $display("FAIL br_target_addr: got=%b/%h want=1/00000100", bus.Imem_req, bus.Imem_addr); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = IF_Valid;
    end
    total++; if (!found || IF_PC !== 32'h100 || IF_Instruction !== mem_word(32'h100)) begin
      bad++; $display("FAIL br_first: found=%0d pc=%h instr=%h want pc=00000100 instr=%h", found, IF_PC, IF_Instruction, mem_word(32'h100)); end
  endtask

  task automatic test_both();
    bit found;
    lat_min = 1; lat_max = 1; ready_mode = 2;
    apply_reset();
    tick();
    EX_PC_Branch = 1'b1; EX_Branch_target = 32'h200;
    ID_Jump = 1'b1; ID_Jump_target = 32'h300;
    tick();
    EX_PC_Branch = 1'b0; ID_Jump = 1'b0;
    total++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h200) begin
      bad++; $display("FAIL both_addr: got=%b/%h want=1/00000200", bus.Imem_req, bus.Imem_addr); end
    ready_mode = 0; bus.Imem_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = IF_Valid;
    end
    total++; if (!found || IF_PC !== 32'h200) begin
      bad++; $display("FAIL both_first: found=%0d pc=%h want 00000200", found, IF_PC); end
  endtask

  task automatic test_flush();
    lat_min = 1; lat_max = 1; ready_mode = 0;
    apply_reset();
    tick(); tick(); tick();  // IF holds 0x0
    Stall = 1'b1;
    tick(); tick();          // 0x4 fetched into the hold buffer
    total++; if (IF_Valid !== 1'b1 || IF_PC !== 32'h0 || bus.Imem_req !== 1'b0) begin
      bad++; $display("FAIL flush_pre: got=%b/%h req=%b want=1/0 req=0", IF_Valid, IF_PC, bus.Imem_req); end
    IF_ID_Flush = 1'b1;
    tick();
    IF_ID_Flush = 1'b0;
    total++; if (IF_Valid !== 1'b0 || IF_Instruction !== NOP) begin
      bad++; $display("FAIL flush_if: got=%b/%h want=0/%h", IF_Valid, IF_Instruction, NOP); end
    total++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h8) begin
      bad++; $display("FAIL flush_hold_empty: got=%b/%h want=1/00000008", bus.Imem_req, bus.Imem_addr); end
    Stall = 1'b0;
    tick();
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL flush_no_reload: got=%b pc=%h want=0", IF_Valid, IF_PC); end
  endtask

  task automatic test_reset_mid();
    bit found;
    lat_min = 3; lat_max = 3; ready_mode = 0;
    apply_reset();
    tick(); tick(); tick();  // in WAIT for 0x0
    rst_n = 1'b0;
    tick();                  // response is driven from here on
    rst_n = 1'b1;
    tick();
    total++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h0 || IF_Valid !== 1'b0) begin
      bad++; $display("FAIL rmid_state: req=%b addr=%h valid=%b want 1/0/0", bus.Imem_req, bus.Imem_addr, IF_Valid); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = IF_Valid;
    end
    total++; if (!found || IF_PC !== 32'h0 || IF_Instruction !== prog[0]) begin
      bad++; $display("FAIL rmid_first: found=%0d pc=%h instr=%h want 0/%h", found, IF_PC, IF_Instruction, prog[0]); end
  endtask

  // Program-order model: the n-th delivered word after a redirect to T is T+4n.
  task automatic test_random(input bit redir_en, input string name);
    logic [31:0] exp_pc, p_instr, p_pc, tgt;
    logic        p_valid;
    bit          st, rd;
    int          delivered;
    lat_min = 1; lat_max = 4; ready_mode = 1;
    apply_reset();
    exp_pc = 32'h0; delivered = 0;
    for (int c = 0; c < 600; c++) begin
      p_instr = IF_Instruction; p_pc = IF_PC; p_valid = IF_Valid;
      st = ($urandom_range(0, 3) == 0);
      rd = redir_en && ($urandom_range(0, 9) == 0);
      Stall = st;
      if (rd) begin
        EX_PC_Branch     = ($urandom_range(0, 1) == 1);
        ID_Jump          = !EX_PC_Branch || ($urandom_range(0, 1) == 1);
        EX_Branch_target = 32'($urandom_range(0, 1023)) << 2;
        ID_Jump_target   = 32'($urandom_range(0, 1023)) << 2;
        IF_ID_Flush      = 1'b1;
        tgt = EX_PC_Branch ? EX_Branch_target : ID_Jump_target;
      end
      tick();
      EX_PC_Branch = 1'b0; ID_Jump = 1'b0; IF_ID_Flush = 1'b0;
      if (rd) begin
        exp_pc = tgt;
        total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL %s_flush c=%0d: got=%b want=0", name, c, IF_Valid); end
      end else if (st) begin
        total++; if (IF_Valid !== p_valid || IF_PC !== p_pc || IF_Instruction !== p_instr) begin
          bad++; $display("FAIL %s_stall c=%0d: got=%b/%h/%h want=%b/%h/%h", name, c, IF_Valid, IF_PC, IF_Instruction, p_valid, p_pc, p_instr); end
      end else if (IF_Valid) begin
        total++; if (IF_PC !== exp_pc || IF_Instruction !== mem_word(exp_pc)) begin
          bad++; $display("FAIL %s_seq c=%0d: got=%h/%h want=%h/%h", name, c, IF_PC, IF_Instruction, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (!IF_Valid) begin
        total++; if (IF_Instruction !== NOP) begin bad++; $display("FAIL %s_nop c=%0d: got=%h want=%h", name, c, IF_Instruction, NOP); end
      end
    end
    Stall = 1'b0;
    total++; if (delivered < 40) begin bad++; $display("FAIL %s_progress: got=%0d want>=40", name, delivered); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 32'h0001_0013 + (32'(i) << 20);
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    bus.Imem_ready = 1'b0; bus.Imem_rvalid = 1'b0; bus.Imem_rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_both();
    test_flush();
    test_reset_mid();
    test_random(1'b0, "rnd_stall");
    test_random(1'b1, "rnd_redirect");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. Owns the program counter, fetches from instruction memory over a request/response handshake, and holds the fetched word in the IF pipeline register feeding decode and the hazard-detection unit. Honours that unit's Stall and IF_ID_Flush outputs and redirects the PC on a taken EX branch or an ID jump.

## Interface
- PC_WIDTH, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, `addi x0,x0,0`, driven on IF_Instruction whenever invalid

Reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Imem_req  out  1  address valid
- Imem_addr  out  PC_WIDTH  fetch address, word aligned
- Imem_ready  in  1  memory accepts the request this cycle
- Imem_rvalid  in  1  response data valid
- Imem_rdata  in  32  fetched instruction
- Stall  in  1  load-use stall from hazard unit
- IF_ID_Flush  in  1  squash the IF register contents
- EX_PC_Branch  in  1  branch taken in EX
- EX_Branch_target  in  PC_WIDTH  branch target
- ID_Jump  in  1  jump taken in ID
- ID_Jump_target  in  PC_WIDTH  jump target
- IF_Instruction  out  32  IF pipeline register, instruction
- IF_PC  out  PC_WIDTH  PC of IF_Instruction
- IF_Valid  out  1  IF register holds a real instruction

## Operation
- Single outstanding request. Memory latency is variable, at least 1 cycle after acceptance. Responses arrive in order.
- FSM states:
  - IDLE: reset state. Moves to FETCH after 1 cycle.
  - FETCH: Imem_req = !hold_valid. Imem_addr = PC. When Imem_req && Imem_ready: PC <= PC+4 (mod 2^PC_WIDTH), req_pc <= PC, go to WAIT.
  - WAIT: on Imem_rvalid, go to FETCH.
  - DISCARD: on Imem_rvalid, drop the data and go to FETCH.
- Imem_req is a function of state and hold_valid only. There is no combinational path from any input to Imem_req or Imem_addr.
- Response delivery in WAIT on Imem_rvalid, with no redirect and no flush:
  - Stall=0 and hold empty: IF register <= {rdata, req_pc}, IF_Valid <= 1.
  - Stall=1: the IF register holds, and the hold buffer captures {rdata, req_pc} with hold_valid <= 1.
- With Stall=0 and hold_valid=1, the IF register <= hold buffer and hold_valid <= 0.
- With Stall=0 and nothing to load, IF_Valid <= 0 and IF_Instruction <= NOP_INSTR (a bubble).
- Redirect = EX_PC_Branch | ID_Jump. If both are asserted, EX_PC_Branch wins and PC <= EX_Branch_target; otherwise PC <= ID_Jump_target. A redirect also cancels any PC+4 increment in the same cycle.
- Effects of a redirect by state:
  - WAIT without rvalid in the same cycle: go to DISCARD.
  - WAIT with rvalid in the same cycle: data dropped, go to FETCH.
  - FETCH with a handshake completing in the same cycle: go to DISCARD.
  - DISCARD: stays in DISCARD.
- IF_ID_Flush does three things:
  - IF register <= NOP_INSTR, IF_Valid <= 0.
  - hold_valid <= 0.
  - Any response delivered in the same cycle is dropped.
- Priority: reset > IF_ID_Flush/redirect > Stall > normal delivery.
- Targets are not checked for alignment; bits [1:0] pass through to Imem_addr.

## Timing
- Values while reset is asserted:
  - IF_Valid = 0, IF_Instruction = NOP_INSTR, IF_PC = RESET_PC.
  - PC = RESET_PC, hold_valid = 0.
  - state = IDLE, Imem_req = 0.
- Reset asserted mid-transaction: outstanding responses after release are ignored (the FSM is in IDLE/FETCH, not WAIT).
- First Imem_req is high in the 2nd cycle after rst_n deasserts.
- Latency: handshake at edge N, rvalid in cycle N+k (k≥1), IF_Instruction valid after edge N+k+1.
- Peak throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- Redirect at edge R: the first request to the target is issued in cycle R+1 if no fetch was outstanding. Otherwise it is issued in the cycle after the discarded rvalid.
- Stall holds IF_Instruction, IF_PC and IF_Valid exactly. At most one extra word is buffered. No request is issued while hold_valid=1.

## Test plan
- Reset then 1-cycle memory returning 0x00500093, 0x00A00113: RESET_PC=0 → Imem_addr 0x0 then 0x4. IF_Instruction shows 0x00500093/IF_PC 0x0, then 0x00A00113/IF_PC 0x4, with a NOP bubble between them.
- Stall held 3 cycles while a response arrives: IF register unchanged. Hold buffer captures the word. Imem_req=0 during the stall. After Stall falls the buffered word appears in the next cycle and fetching resumes at PC+4.
- EX_PC_Branch=1, target 0x100, with a request outstanding (latency 3): the FSM enters DISCARD and the stale rdata never reaches IF_Instruction. The next Imem_addr is 0x100, and IF_Valid=0 until it returns.
- EX_PC_Branch and ID_Jump in the same cycle with targets 0x200/0x300: next fetch is 0x200.
- IF_ID_Flush with hold_valid=1 and Stall=1: IF_Instruction=0x00000013, IF_Valid=0, and the hold buffer is emptied.
- rst_n pulled low while in WAIT, then released as rvalid arrives: the response is ignored and the first fetch is RESET_PC.
